pipeline_mem_wb_hs: RTL and testbench
=====================================

// Module: pipeline_mem_wb_hs
// PURPOSE
//  MEM->WB pipeline stage, generalised: valid/ready handshake on both sides, optional
//  2-entry skid buffer, synchronous flush, x0 write suppression, retired-instruction counter.
//  Sits between data-memory stage and register-file writeback; lets WB stall (RF port
//  conflict, multi-cycle load) without a combinational ready path back into MEM.
// PARAMETERS
//  WIDTH      32  datapath width (ALUResult, ReadData, PCP4)
//  REG_AW     5   register index width (Rd)
//  SKID       1   1: skid buffer, ready_M registered; 0: single register, ready_M combinational
//  CNT_W      32  retired-counter width
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous reset, active-high
//  flush         in   1        kill all held entries (trap/redirect)
//  valid_M       in   1        MEM beat valid
//  ready_M       out  1        stage can accept a MEM beat
//  ALUResult_M   in   WIDTH    ALU result
//  ReadData_M    in   WIDTH    load data
//  PCP4_M        in   WIDTH    PC+4
//  Rd_M          in   REG_AW   destination register
//  RegWrite_M    in   1        writeback enable
//  ResultSrc_M   in   2        result mux select
//  valid_W       out  1        WB beat valid
//  ready_W       in   1        WB consumes beat this cycle
//  ALUResult_W / ReadData_W / PCP4_W  out WIDTH; Rd_W out REG_AW; ResultSrc_W out 2
//  RegWrite_W    out  1        RegWrite_reg & valid_W & (Rd_W != 0)
//  retired       out  CNT_W    count of beats consumed by WB
// BEHAVIOUR
//  - Reset (async): valid_W=0, all payload outputs 0, RegWrite_W=0, retired=0, skid empty,
//    ready_M=1 (SKID=1). Payload registers in reset domain (no X on outputs).
//  - Transfer in: valid_M & ready_M at edge. Transfer out: valid_W & ready_W at edge.
//  - Latency: accepted beat appears on *_W the next cycle when output reg empty or draining.
//  - SKID=1 states (enum): EMPTY (no data), ONE (output reg only), TWO (output + skid).
//     EMPTY: in -> ONE.  ONE: in&!out -> TWO; out&!in -> EMPTY; in&out -> ONE (new beat).
//     TWO: out -> ONE, skid moves to output reg; in impossible (ready_M=0).
//    ready_M = (state != TWO), registered; no combinational path from ready_W.
//  - SKID=0: ready_M = !valid_W | ready_W (combinational); no skid reg; states EMPTY/ONE.
//  - Ordering strictly FIFO; payload never modified in flight.
//  - flush: next state EMPTY, valid_W=0, ready_M=1 next cycle; a beat accepted in the same
//    cycle as flush is dropped; flush beats out-transfer (no retire count that cycle).
//  - Payload held stable while valid_W & !ready_W.
//  - RegWrite_W forced 0 for Rd_W==0 and whenever valid_W=0.
//  - retired += 1 on each out-transfer; wraps modulo 2^CNT_W.
//  - Reset mid-operation: all held beats discarded immediately (async).
// STRUCTURE
//  - Package pipeline_pkg: wb_payload_t struct {ALUResult, ReadData, PCP4, Rd, RegWrite,
//    ResultSrc}; ResultSrc encodings RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10;
//    hs_state_e {EMPTY, ONE, TWO}.
//  - Sub-module pipe_skid_reg #(type T) holds handshake + skid logic; this block wraps it
//    and adds x0 suppression and counter.
// TESTING
//  - Stream 8 beats, ready_W=1 always -> each on *_W 1 cycle after accept, retired=8,
//    ready_M never drops.
//  - ready_W=0 for 3 cycles while valid_M=1 (SKID=1) -> 2 beats held, ready_M=0 from
//    cycle 2, no loss; release -> beats emerge in order, ALUResult 0x10,0x20.
//  - flush with state TWO and valid_M=1 same cycle -> valid_W=0 next cycle, incoming beat
//    dropped, retired unchanged, ready_M=1.
//  - Beat Rd_M=0, RegWrite_M=1 -> RegWrite_W=0; Rd_M=5 -> RegWrite_W=1 while valid.
//  - Async rst asserted mid-clock with 2 beats held -> valid_W=0, outputs 0 before next edge.
//  - CNT_W=4, 17 out-transfers -> retired=1 (wrap); repeat key cases with SKID=0.

Source files
------------

// File: rtl/pipeline_mem_wb_hs_pkg.sv
// Shared types for the MEM->WB handshake stage: payload layout, result-select codes
// and the occupancy states of the handshake register.
package pipeline_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } hs_state_e;

  typedef struct packed {
    logic [WIDTH_DEF-1:0]  ALUResult;
    logic [WIDTH_DEF-1:0]  ReadData;
    logic [WIDTH_DEF-1:0]  PCP4;
    logic [REG_AW_DEF-1:0] Rd;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
  } wb_payload_t;

endpackage

// File: rtl/pipeline_mem_wb_hs_skid.sv
// Valid/ready register slice with an optional second (skid) entry; the payload type is a
// parameter so the same slice can carry any packed struct in strict FIFO order.
module pipe_skid_reg
  import pipeline_pkg::*;
#(
  parameter type T    = logic,
  parameter bit  SKID = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  hs_state_e state, state_next;
  T          skid_data;
  logic      in_fire, out_fire;
  logic      load_out_in, load_out_skid, load_skid;

  // With the skid entry, ready depends only on registered state, so WB stalls never
  // reach MEM combinationally.
  assign out_valid = (state != EMPTY);
  assign in_ready  = SKID ? (state != TWO) : (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next  = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_out_in = 1'b1;
          end else if (in_fire) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_next    = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_out_in)        out_data <= in_data;
      else if (load_out_skid) out_data <= skid_data;
      if (load_skid)          skid_data <= in_data;
    end
  end

endmodule

// File: rtl/pipeline_mem_wb_hs.sv
// MEM->WB pipeline stage: handshake slice around the writeback payload, plus x0 write
// suppression and a retired-instruction counter.
module pipeline_mem_wb_hs
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_M,
  output logic              ready_M,
  input  logic [WIDTH-1:0]  ALUResult_M,
  input  logic [WIDTH-1:0]  ReadData_M,
  input  logic [WIDTH-1:0]  PCP4_M,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic              RegWrite_M,
  input  logic [1:0]        ResultSrc_M,
  output logic              valid_W,
  input  logic              ready_W,
  output logic [WIDTH-1:0]  ALUResult_W,
  output logic [WIDTH-1:0]  ReadData_W,
  output logic [WIDTH-1:0]  PCP4_W,
  output logic [REG_AW-1:0] Rd_W,
  output logic [1:0]        ResultSrc_W,
  output logic              RegWrite_W,
  output logic [CNT_W-1:0]  retired
);

  // Same layout as wb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [WIDTH-1:0]  ALUResult;
    logic [WIDTH-1:0]  ReadData;
    logic [WIDTH-1:0]  PCP4;
    logic [REG_AW-1:0] Rd;
    logic              RegWrite;
    logic [1:0]        ResultSrc;
  } payload_t;

  payload_t in_pay, out_pay;

  assign in_pay = '{ALUResult: ALUResult_M, ReadData: ReadData_M, PCP4: PCP4_M,
                    Rd: Rd_M, RegWrite: RegWrite_M, ResultSrc: ResultSrc_M};

  pipe_skid_reg #(
    .T    (payload_t),
    .SKID (SKID)
  ) u_hs (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (valid_M),
    .in_ready  (ready_M),
    .in_data   (in_pay),
    .out_valid (valid_W),
    .out_ready (ready_W),
    .out_data  (out_pay)
  );

  assign ALUResult_W = out_pay.ALUResult;
  assign ReadData_W  = out_pay.ReadData;
  assign PCP4_W      = out_pay.PCP4;
  assign Rd_W        = out_pay.Rd;
  assign ResultSrc_W = out_pay.ResultSrc;
  assign RegWrite_W  = out_pay.RegWrite && valid_W && (out_pay.Rd != '0);

  // A beat killed by flush is not a retirement even if WB was ready for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                retired <= '0;
    else if (valid_W && ready_W && !flush) retired <= retired + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_mem_wb_hs.sv
// Bench for pipeline_mem_wb_hs: a skid instance and a combinational-ready instance share
// the same stimulus and are each compared against a queue-based model.
module tb_pipeline_mem_wb_hs;
  import pipeline_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pcp4;
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  src;
  } beat_t;

  typedef struct {
    logic [4:0]  rd;
    logic        regw;
    logic [1:0]  src;
    logic [31:0] alu;
    logic        exp_regwrite;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, valid_M, ready_W, RegWrite_M;
  logic [31:0] ALUResult_M, ReadData_M, PCP4_M;
  logic [4:0]  Rd_M;
  logic [1:0]  ResultSrc_M;

  logic        s_ready_M, s_valid_W, s_RegWrite_W;
  logic [31:0] s_ALUResult_W, s_ReadData_W, s_PCP4_W, s_retired;
  logic [4:0]  s_Rd_W;
  logic [1:0]  s_ResultSrc_W;

  logic        c_ready_M, c_valid_W, c_RegWrite_W;
  logic [31:0] c_ALUResult_W, c_ReadData_W, c_PCP4_W;
  logic [3:0]  c_retired;
  logic [4:0]  c_Rd_W;
  logic [1:0]  c_ResultSrc_W;

  int total = 0;
  int bad = 0;

  beat_t q1[$];
  beat_t q0[$];
  logic [31:0] ret1;
  logic [3:0]  ret0;
  bit exp_rdy1, exp_rdy0;
  vec_t tbl[5];

  always #5 clk = ~clk;

  pipeline_mem_wb_hs #(.WIDTH(32), .REG_AW(5), .SKID(1'b1), .CNT_W(32)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(s_ready_M),
    .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M), .PCP4_M(PCP4_M), .Rd_M(Rd_M),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .valid_W(s_valid_W), .ready_W(ready_W),
    .ALUResult_W(s_ALUResult_W), .ReadData_W(s_ReadData_W), .PCP4_W(s_PCP4_W), .Rd_W(s_Rd_W),
    .ResultSrc_W(s_ResultSrc_W), .RegWrite_W(s_RegWrite_W), .retired(s_retired)
  );

  pipeline_mem_wb_hs #(.WIDTH(32), .REG_AW(5), .SKID(1'b0), .CNT_W(4)) dut_comb (
    .clk(clk), .rst(rst), .flush(flush), .valid_M(valid_M), .ready_M(c_ready_M),
    .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M), .PCP4_M(PCP4_M), .Rd_M(Rd_M),
    .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M), .valid_W(c_valid_W), .ready_W(ready_W),
    .ALUResult_W(c_ALUResult_W), .ReadData_W(c_ReadData_W), .PCP4_W(c_PCP4_W), .Rd_W(c_Rd_W),
    .ResultSrc_W(c_ResultSrc_W), .RegWrite_W(c_RegWrite_W), .retired(c_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkBeat(input logic [31:0] alu);
    beat_t b;
    b.alu   = alu;
    b.rdata = alu ^ 32'hA5A5_0000;
    b.pcp4  = alu + 32'd4;
    b.rd    = alu[4:0] | 5'd1;
    b.regw  = 1'b1;
    b.src   = RES_MEM;
    return b;
  endfunction

  task automatic checkDut(input string tag, input int n, input beat_t h, input bit exp_rdy,
                          input logic [31:0] exp_ret, input logic valid, input logic rdy,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] pcp4, input logic [4:0] rd, input logic [1:0] src,
                          input logic regw, input logic [31:0] ret);
    chk({tag, ".valid_W"}, 32'(valid), 32'(n > 0));
    chk({tag, ".ready_M"}, 32'(rdy), 32'(exp_rdy));
    chk({tag, ".retired"}, ret, exp_ret);
    chk({tag, ".RegWrite_W"}, 32'(regw), 32'(n > 0 && h.regw && h.rd != 5'd0));
    if (n > 0) begin
      chk({tag, ".ALUResult_W"}, alu, h.alu);
      chk({tag, ".ReadData_W"}, rdata, h.rdata);
      chk({tag, ".PCP4_W"}, pcp4, h.pcp4);
      chk({tag, ".Rd_W"}, 32'(rd), 32'(h.rd));
      chk({tag, ".ResultSrc_W"}, 32'(src), 32'(h.src));
    end
  endtask

  task automatic checkOutput();
    beat_t h1, h0;
    h1 = '0;
    h0 = '0;
    if (q1.size() > 0) h1 = q1[0];
    if (q0.size() > 0) h0 = q0[0];
    exp_rdy1 = (q1.size() < 2);
    exp_rdy0 = (q0.size() == 0) || ready_W;
    checkDut("skid", q1.size(), h1, exp_rdy1, ret1, s_valid_W, s_ready_M, s_ALUResult_W,
             s_ReadData_W, s_PCP4_W, s_Rd_W, s_ResultSrc_W, s_RegWrite_W, s_retired);
    checkDut("comb", q0.size(), h0, exp_rdy0, 32'(ret0), c_valid_W, c_ready_M, c_ALUResult_W,
             c_ReadData_W, c_PCP4_W, c_Rd_W, c_ResultSrc_W, c_RegWrite_W, 32'(c_retired));
  endtask

  // Drive one cycle, compare before the edge, then advance the model across the edge.
  task automatic applyStimulus(input bit vm, input bit rw, input bit fl, input beat_t b);
    @(negedge clk);
    valid_M = vm; ready_W = rw; flush = fl;
    ALUResult_M = b.alu; ReadData_M = b.rdata; PCP4_M = b.pcp4;
    Rd_M = b.rd; RegWrite_M = b.regw; ResultSrc_M = b.src;
    #1;
    checkOutput();
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && rw) begin q1.delete(0); ret1 = ret1 + 32'd1; end
      if (vm && exp_rdy1) q1.push_back(b);
      if (q0.size() > 0 && rw) begin q0.delete(0); ret0 = ret0 + 4'd1; end
      if (vm && exp_rdy0) q0.push_back(b);
    end
  endtask

  initial begin
    beat_t b;
    logic [31:0] saved_ret1;
    logic [3:0]  saved_ret0;

    tbl[0] = '{rd: 5'd0,  regw: 1'b1, src: RES_ALU, alu: 32'h0000_0011, exp_regwrite: 1'b0};
    tbl[1] = '{rd: 5'd5,  regw: 1'b1, src: RES_MEM, alu: 32'h0000_0022, exp_regwrite: 1'b1};
    tbl[2] = '{rd: 5'd5,  regw: 1'b0, src: RES_PC4, alu: 32'h0000_0033, exp_regwrite: 1'b0};
    tbl[3] = '{rd: 5'd31, regw: 1'b1, src: RES_ALU, alu: 32'h0000_0044, exp_regwrite: 1'b1};
    tbl[4] = '{rd: 5'd0,  regw: 1'b0, src: RES_MEM, alu: 32'h0000_0055, exp_regwrite: 1'b0};

    rst = 1'b1; flush = 1'b0; valid_M = 1'b0; ready_W = 1'b0;
    ALUResult_M = '0; ReadData_M = '0; PCP4_M = '0; Rd_M = '0; RegWrite_M = 1'b0;
    ResultSrc_M = '0;
    ret1 = '0; ret0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.valid_W", 32'(s_valid_W), 32'd0);
    chk("reset.ALUResult_W", s_ALUResult_W, 32'd0);
    chk("reset.ReadData_W", s_ReadData_W, 32'd0);
    chk("reset.PCP4_W", s_PCP4_W, 32'd0);
    chk("reset.Rd_W", 32'(s_Rd_W), 32'd0);
    chk("reset.RegWrite_W", 32'(s_RegWrite_W), 32'd0);
    chk("reset.retired", s_retired, 32'd0);
    chk("reset.ready_M", 32'(s_ready_M), 32'd1);
    chk("reset.comb_valid_W", 32'(c_valid_W), 32'd0);
    chk("reset.comb_ready_M", 32'(c_ready_M), 32'd1);

    // Streaming with WB always ready.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(32'h100 + 32'(i)));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    #1;
    chk("stream.retired_skid", s_retired, 32'd8);
    chk("stream.retired_comb", 32'(c_retired), 32'd8);

    // WB stalls three cycles: two beats held, then released in order.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(32'(16 * (k + 1))));
    #1;
    chk("stall.ready_M", 32'(s_ready_M), 32'd0);
    chk("stall.head", s_ALUResult_W, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(32'h30));
    #1;
    chk("stall.second", s_ALUResult_W, 32'h20);
    applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(32'h30));
    #1;
    chk("stall.third", s_ALUResult_W, 32'h30);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);

    // Flush while full, with a new beat offered in the same cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(32'hA1));
    applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(32'hA2));
    saved_ret1 = ret1;
    saved_ret0 = ret0;
    applyStimulus(1'b1, 1'b1, 1'b1, mkBeat(32'hA3));
    #1;
    chk("flush.valid_skid", 32'(s_valid_W), 32'd0);
    chk("flush.valid_comb", 32'(c_valid_W), 32'd0);
    chk("flush.ready_M", 32'(s_ready_M), 32'd1);
    chk("flush.retired_skid", s_retired, saved_ret1);
    chk("flush.retired_comb", 32'(c_retired), 32'(saved_ret0));

    // x0 suppression and ResultSrc pass-through, one row per beat.
    for (int i = 0; i < 5; i++) begin
      b.alu = tbl[i].alu; b.rdata = ~tbl[i].alu; b.pcp4 = tbl[i].alu + 32'd4;
      b.rd = tbl[i].rd; b.regw = tbl[i].regw; b.src = tbl[i].src;
      applyStimulus(1'b1, 1'b1, 1'b0, b);
      #1;
      chk("tbl.RegWrite_skid", 32'(s_RegWrite_W), 32'(tbl[i].exp_regwrite));
      chk("tbl.RegWrite_comb", 32'(c_RegWrite_W), 32'(tbl[i].exp_regwrite));
      chk("tbl.Rd_W", 32'(s_Rd_W), 32'(tbl[i].rd));
      chk("tbl.ResultSrc_W", 32'(s_ResultSrc_W), 32'(tbl[i].src));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    #1;
    chk("tbl.idle_RegWrite", 32'(s_RegWrite_W), 32'd0);

    // Asynchronous reset in mid-cycle with two beats held.
    applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(32'hB1));
    applyStimulus(1'b1, 1'b0, 1'b0, mkBeat(32'hB2));
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid_W", 32'(s_valid_W), 32'd0);
    chk("arst.ALUResult_W", s_ALUResult_W, 32'd0);
    chk("arst.ReadData_W", s_ReadData_W, 32'd0);
    chk("arst.PCP4_W", s_PCP4_W, 32'd0);
    chk("arst.Rd_W", 32'(s_Rd_W), 32'd0);
    chk("arst.RegWrite_W", 32'(s_RegWrite_W), 32'd0);
    chk("arst.retired", s_retired, 32'd0);
    chk("arst.ready_M", 32'(s_ready_M), 32'd1);
    chk("arst.comb_valid_W", 32'(c_valid_W), 32'd0);
    q1.delete(); q0.delete();
    ret1 = '0; ret0 = '0;
    valid_M = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Counter wrap on the 4-bit instance after 17 retirements.
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 1'b0, mkBeat(32'h200 + 32'(i)));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    #1;
    chk("wrap.retired_comb", 32'(c_retired), 32'd1);
    chk("wrap.retired_skid", s_retired, 32'd17);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      b.alu = $urandom; b.rdata = $urandom; b.pcp4 = $urandom;
      b.rd = 5'($urandom); b.regw = 1'($urandom); b.src = 2'($urandom_range(0, 2));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, b);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
